fifo_sync_ram_ctrl: RTL and testbench

Single-clock FIFO controller with an integrated inferred dual-port RAM, parametrised in data width, depth (any integer ≥ 2, not only powers of two) and read-pipeline depth. It adds registered full, empty, almost-full and almost-empty flags, an occupancy count, overflow and underflow error pulses, a synchronous flush, and a read-data valid strobe. It sits between single-clock producer/consumer logic, such as camera pixel capture and the LCD write path, where a plain RAM wrapper needs an external controller.

---
 rtl/fifo_sync_ram_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fifo_sync_ram_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_ram_ctrl.sv
// fifo_sync_ram_ctrl
// Single-clock FIFO controller around an inferred dual-port RAM. DEPTH can be any
// integer >= 2 because the pointers wrap by explicit compare. The occupancy count
// is tracked directly, and every status flag is computed from the next count and
// registered with it, so all outputs come straight from flops.
//
// Ports:
//   CLOCK      in   rising-edge system clock
//   RESET_N    in   asynchronous active-low reset
//   SCLR       in   synchronous flush; overrides WE/RE and cancels reads in flight
//   WDATA      in   write data (WIDTH)
//   WE / RE    in   write / read requests
//   RDATA      out  read data (WIDTH); holds its value between reads
//   DVLD       out  one-cycle strobe marking RDATA valid for an accepted read
//   FULL, EMPTY, AFULL, AEMPTY   out  registered occupancy flags
//   COUNT      out  occupancy (CW bits)
//   OVERFLOW / UNDERFLOW  out  registered pulses for a rejected write / read
module fifo_sync_ram_ctrl #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 1024,
    parameter int PIPE       = 1,
    parameter int AFULL_VAL  = DEPTH - 2,
    parameter int AEMPTY_VAL = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             SCLR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             WE,
    input  logic             RE,
    output logic [WIDTH-1:0] RDATA,
    output logic             DVLD,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic [CW-1:0]    COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_go_s;
    logic             rd_go_s;
    logic [WIDTH-1:0] rdata_q;
    logic             dvld_q;

    // Accepts use the registered flags; the flush suppresses both accesses.
    always_comb begin
        wr_go_s = WE & ~full_q & ~SCLR;
        rd_go_s = RE & ~empty_q & ~SCLR;
    end

    // Next-state for pointers, occupancy, flags and error pulses.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = WE & full_q & ~SCLR;
        unf_d   = RE & empty_q & ~SCLR;
        if (SCLR) begin
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            wptr_d = wr_go_s ? ((wptr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : wptr_q + AW'(1)) : wptr_q;
            rptr_d = rd_go_s ? ((rptr_q == AW'(DEPTH - 1)) ? {AW{1'b0}} : rptr_q + AW'(1)) : rptr_q;
            case ({wr_go_s, rd_go_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == {CW{1'b0}});
        afull_d  = (count_d >= CW'(AFULL_VAL));
        aempty_d = (count_d <= CW'(AEMPTY_VAL));
    end

    // Control state registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q   <= {AW{1'b0}};
            rptr_q   <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // RAM write port; contents are deliberately never reset.
    always_ff @(posedge CLOCK) begin
        if (wr_go_s) begin
            mem[wptr_q] <= WDATA;
        end
    end

    generate
        if (PIPE == 0) begin : g_pipe0
            // Synchronous RAM read lands directly in the output register.
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    rdata_q <= {WIDTH{1'b0}};
                    dvld_q  <= 1'b0;
                end else begin
                    dvld_q <= rd_go_s;
                    if (rd_go_s) begin
                        rdata_q <= mem[rptr_q];
                    end
                end
            end
        end else begin : g_pipe1
            logic [WIDTH-1:0] ram_q;
            logic             v1_q;

            // First stage: plain RAM read register, no reset so it maps onto block RAM.
            always_ff @(posedge CLOCK) begin
                if (rd_go_s) begin
                    ram_q <= mem[rptr_q];
                end
            end

            // Second stage: output register; a flush kills a read sitting in stage one.
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    v1_q    <= 1'b0;
                    rdata_q <= {WIDTH{1'b0}};
                    dvld_q  <= 1'b0;
                end else begin
                    v1_q   <= rd_go_s;
                    dvld_q <= v1_q & ~SCLR;
                    if (v1_q && !SCLR) begin
                        rdata_q <= ram_q;
                    end
                end
            end
        end
    endgenerate

    assign RDATA     = rdata_q;
    assign DVLD      = dvld_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign AFULL     = afull_q;
    assign AEMPTY    = aempty_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_fifo_sync_ram_ctrl.sv
// Bench for fifo_sync_ram_ctrl: two instances (PIPE=0 and PIPE=1, DEPTH=6, WIDTH=8)
// driven with identical stimulus. A vector table supplies inputs and hand-derived
// COUNT/OVERFLOW/UNDERFLOW; read data and DVLD timing come from a reference queue
// and per-instance scoreboards.
module tb_fifo_sync_ram_ctrl;

    localparam int D = 6;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       SCLR;
    logic [7:0] WDATA;
    logic       WE;
    logic       RE;

    logic [7:0] rd   [2];
    logic       dv   [2];
    logic       fu   [2];
    logic       em   [2];
    logic       af   [2];
    logic       ae   [2];
    logic [2:0] cnt  [2];
    logic       ovf  [2];
    logic       unf  [2];

    always #5 CLOCK = ~CLOCK;

    fifo_sync_ram_ctrl #(.WIDTH(8), .DEPTH(D), .PIPE(0), .AFULL_VAL(5), .AEMPTY_VAL(1)) u_p0 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SCLR(SCLR), .WDATA(WDATA), .WE(WE), .RE(RE),
        .RDATA(rd[0]), .DVLD(dv[0]), .FULL(fu[0]), .EMPTY(em[0]), .AFULL(af[0]),
        .AEMPTY(ae[0]), .COUNT(cnt[0]), .OVERFLOW(ovf[0]), .UNDERFLOW(unf[0]));

    fifo_sync_ram_ctrl #(.WIDTH(8), .DEPTH(D), .PIPE(1), .AFULL_VAL(5), .AEMPTY_VAL(1)) u_p1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SCLR(SCLR), .WDATA(WDATA), .WE(WE), .RE(RE),
        .RDATA(rd[1]), .DVLD(dv[1]), .FULL(fu[1]), .EMPTY(em[1]), .AFULL(af[1]),
        .AEMPTY(ae[1]), .COUNT(cnt[1]), .OVERFLOW(ovf[1]), .UNDERFLOW(unf[1]));

    typedef struct {
        logic       we;
        logic       re;
        logic       sclr;
        logic [7:0] wd;
        int         ecnt;
        logic       eovf;
        logic       eunf;
    } vec_t;

    vec_t vecs[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    int         m_cnt = 0;
    logic       pend1 = 1'b0;
    logic [7:0] last_rd [2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic sclr, input logic [7:0] wd,
                       input int ecnt, input logic eovf, input logic eunf);
        vec_t v;
        v.we = we; v.re = re; v.sclr = sclr; v.wd = wd;
        v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        mq.delete();
        sb0.delete();
        sb1.delete();
        m_cnt = 0;
        pend1 = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
    endtask

    task automatic check_outputs(input int ecnt, input logic eovf, input logic eunf,
                                 input logic edv0, input logic edv1);
        logic edv;
        for (int k = 0; k < 2; k++) begin
            edv = (k == 0) ? edv0 : edv1;
            chk($sformatf("d%0d_count", k), longint'(cnt[k]), longint'(ecnt));
            chk($sformatf("d%0d_full", k), longint'(fu[k]), longint'(ecnt == D));
            chk($sformatf("d%0d_empty", k), longint'(em[k]), longint'(ecnt == 0));
            chk($sformatf("d%0d_afull", k), longint'(af[k]), longint'(ecnt >= 5));
            chk($sformatf("d%0d_aempty", k), longint'(ae[k]), longint'(ecnt <= 1));
            chk($sformatf("d%0d_overflow", k), longint'(ovf[k]), longint'(eovf));
            chk($sformatf("d%0d_underflow", k), longint'(unf[k]), longint'(eunf));
            chk($sformatf("d%0d_dvld", k), longint'(dv[k]), longint'(edv));
            if (edv) begin
                if (k == 0 && sb0.size() > 0) last_rd[0] = sb0.pop_front();
                else if (k == 1 && sb1.size() > 0) last_rd[1] = sb1.pop_front();
                else chk($sformatf("d%0d_scoreboard_empty", k), longint'(1), longint'(0));
            end
            chk($sformatf("d%0d_rdata", k), longint'(rd[k]), longint'(last_rd[k]));
        end
    endtask

    task automatic step(input logic we, input logic re, input logic sclr, input logic [7:0] wd,
                        input int ecnt, input logic eovf, input logic eunf);
        logic       wa, ra, edv0, edv1;
        logic [7:0] d;
        WE = we; RE = re; SCLR = sclr; WDATA = wd;
        wa = we && (m_cnt != D) && !sclr;
        ra = re && (m_cnt != 0) && !sclr;
        @(posedge CLOCK);
        #1;
        WE = 1'b0; RE = 1'b0; SCLR = 1'b0;
        edv1 = pend1 && !sclr;
        if (pend1 && sclr && sb1.size() > 0) void'(sb1.pop_front());
        if (ra) begin
            d = mq.pop_front();
            sb0.push_back(d);
            sb1.push_back(d);
        end
        if (wa) mq.push_back(wd);
        if (sclr) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + int'(wa) - int'(ra);
        end
        edv0  = ra;
        pend1 = ra;
        check_outputs(ecnt, eovf, eunf, edv0, edv1);
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        #1;
        model_reset();
        check_outputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        check_outputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Fill to FULL, then one rejected write
        for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 1'b0, 8'(8'h11 + i), i + 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'h17, 6, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 6, 1'b0, 1'b0);
        // WE & RE at FULL: read 0x11, write rejected
        add(1'b1, 1'b1, 1'b0, 8'h99, 5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 8'h00, 4 - i, 1'b0, 1'b0);
        // Read at EMPTY, then WE & RE at EMPTY with 0xA5, then read it back
        add(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        // Single word latency
        add(1'b1, 1'b0, 1'b0, 8'h3C, 1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        // Back-to-back reads, including a both-accepted cycle
        for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), i + 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h44, 4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, 8'h00, 3 - i, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);

        model_reset();
        RESET_N = 1'b0; SCLR = 1'b0; WE = 1'b0; RE = 1'b0; WDATA = 8'h00;
        repeat (2) @(posedge CLOCK);
        #1;
        check_outputs(0, 1'b0, 1'b0, 1'b0, 1'b0);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].we, vecs[i].re, vecs[i].sclr, vecs[i].wd, vecs[i].ecnt, vecs[i].eovf, vecs[i].eunf);

        // Interleaved write/read pairs carry both pointers across the 5->0 wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        end

        // Flush with COUNT=4 and a read in flight; WE/RE during flush are ignored
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i), i + 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hEE, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);

        // Reset pulse with a read in flight
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), i + 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 4, 1'b0, 1'b0);
        pulse_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h70, 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
